mini_i_mem_responder: RTL and testbench

//  Responder end of the instruction-fetch valid/ready protocol used by mini_i_cache.
//  - Accepts one word address on the address channel.
//  - After a fixed, parameterised latency, returns the word from an internal array on the data channel.
//  - Serves as the backing instruction memory behind the cache and as a bench model.
//  - Has a preload write port so tests and boot code can fill the array.

---
 rtl/mini_i_mem_responder.sv | 99 +++++++++
 tb/tb_mini_i_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_i_mem_responder.sv
// mini_i_mem_responder: responder end of the instruction-fetch valid/ready
// protocol. Accepts one word address, waits a fixed latency, then returns the
// addressed word (or an error) and holds it until the requester takes it.
// A preload port writes the internal word array at any time, even in reset.
module mini_i_mem_responder #(
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int depth_log2 = 8,
    parameter int latency    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_addr_valid,
    output logic                  req_addr_ready,
    input  logic [addr_width-1:0] req_addr,
    output logic                  rsp_data_valid,
    input  logic                  rsp_data_ready,
    output logic [data_width-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [depth_log2-1:0] load_addr,
    input  logic [data_width-1:0] load_data
);

    localparam int depth = 1 << depth_log2;
    localparam int cnt_w = (latency > 2) ? $clog2(latency) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [cnt_w-1:0]      cnt;
    logic [data_width-1:0] mem [depth];
    logic [depth_log2-1:0] word_index;
    logic [addr_width-1:0] upper_bits;
    logic                  addr_err;
    logic                  accept;

    assign word_index     = req_addr[depth_log2+1:2];
    assign upper_bits     = req_addr >> (depth_log2 + 2);
    assign addr_err       = (req_addr[1:0] != 2'b00) || (upper_bits != '0);
    assign req_addr_ready = (state == IDLE) && !rst;
    assign accept         = req_addr_valid && req_addr_ready;

    // Preload writes; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Transaction FSM: capture the word at accept, count out the latency, hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rsp_data_valid <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_data <= addr_err ? '0 : mem[word_index];
                        rsp_err  <= addr_err;
                        if (latency == 1) begin
                            state          <= RESP;
                            rsp_data_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= cnt_w'(latency - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - cnt_w'(1);
                    if (cnt == cnt_w'(1)) begin
                        state          <= RESP;
                        rsp_data_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_data_ready) begin
                        state          <= IDLE;
                        rsp_data_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    rsp_data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_i_mem_responder.sv
// Testbench for mini_i_mem_responder: reset, table-driven fetches, load
// collision, reset mid-transaction and randomized fetches against a word-array
// reference model.
module tb_mini_i_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_addr_valid;
    logic        req_addr_ready;
    logic [31:0] req_addr;
    logic        rsp_data_valid;
    logic        rsp_data_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    int checks;
    int failures;

    logic [31:0] model_mem [256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs [8];

    mini_i_mem_responder #(
        .data_width(32),
        .addr_width(32),
        .depth_log2(8),
        .latency(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_addr_valid(req_addr_valid),
        .req_addr_ready(req_addr_ready),
        .req_addr(req_addr),
        .rsp_data_valid(rsp_data_valid),
        .rsp_data_ready(rsp_data_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic loadWord(input logic [7:0] idx, input logic [31:0] val);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = val;
        step();
        load_en = 1'b0;
        model_mem[idx] = val;
    endtask

    // One full transaction: accept, latency, backpressure for hold cycles, handshake
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_data,
                                 input logic exp_err, input int hold, input logic coll,
                                 input logic [7:0] coll_idx, input logic [31:0] coll_val,
                                 input string tag);
        checkOutput({tag, " idle_ready"}, {31'b0, req_addr_ready}, 32'd1);
        checkOutput({tag, " idle_valid"}, {31'b0, rsp_data_valid}, 32'd0);
        req_addr_valid = 1'b1;
        req_addr       = addr;
        if (coll) begin
            load_en   = 1'b1;
            load_addr = coll_idx;
            load_data = coll_val;
        end
        step();
        req_addr_valid = 1'b0;
        load_en        = 1'b0;
        if (coll) model_mem[coll_idx] = coll_val;
        for (int i = 1; i < LAT; i++) begin
            checkOutput({tag, " wait_valid"}, {31'b0, rsp_data_valid}, 32'd0);
            checkOutput({tag, " wait_ready"}, {31'b0, req_addr_ready}, 32'd0);
            req_addr       = $urandom();
            rsp_data_ready = 1'($urandom_range(0, 1));
            step();
        end
        rsp_data_ready = 1'b0;
        checkOutput({tag, " resp_valid"}, {31'b0, rsp_data_valid}, 32'd1);
        checkOutput({tag, " resp_data"}, rsp_data, exp_data);
        checkOutput({tag, " resp_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        checkOutput({tag, " resp_ready"}, {31'b0, req_addr_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_addr = $urandom();
            step();
            checkOutput({tag, " hold_valid"}, {31'b0, rsp_data_valid}, 32'd1);
            checkOutput({tag, " hold_data"}, rsp_data, exp_data);
            checkOutput({tag, " hold_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
            checkOutput({tag, " hold_ready"}, {31'b0, req_addr_ready}, 32'd0);
        end
        rsp_data_ready = 1'b1;
        step();
        rsp_data_ready = 1'b0;
        checkOutput({tag, " done_valid"}, {31'b0, rsp_data_valid}, 32'd0);
        checkOutput({tag, " done_ready"}, {31'b0, req_addr_ready}, 32'd1);
        checkOutput({tag, " done_data"}, rsp_data, exp_data);
    endtask

    // Main test sequence
    initial begin
        logic [31:0] a;
        logic [31:0] ed;
        logic        ee;
        logic        coll;
        logic [7:0]  cidx;
        logic [31:0] cval;
        int          kind;

        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        req_addr_valid = 1'b1;
        req_addr       = 32'h14;
        rsp_data_ready = 1'b0;
        load_en        = 1'b0;
        load_addr      = '0;
        load_data      = '0;

        // Reset held 3 cycles with a pending request; preload during reset
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                load_en   = 1'b1;
                load_addr = 8'd5;
                load_data = 32'hDEADBEEF;
            end
            step();
            load_en = 1'b0;
            checkOutput("rst_ready", {31'b0, req_addr_ready}, 32'd0);
            checkOutput("rst_valid", {31'b0, rsp_data_valid}, 32'd0);
            checkOutput("rst_data", rsp_data, 32'd0);
            checkOutput("rst_err", {31'b0, rsp_err}, 32'd0);
        end
        model_mem[5] = 32'hDEADBEEF;
        rst            = 1'b0;
        req_addr_valid = 1'b0;
        #1;
        checkOutput("post_rst_ready", {31'b0, req_addr_ready}, 32'd1);
        step();
        checkOutput("post_rst_ready2", {31'b0, req_addr_ready}, 32'd1);

        // Table-driven vectors
        loadWord(8'd0, 32'hA5A50001);
        loadWord(8'd255, 32'hCAFEF00D);
        loadWord(8'd1, 32'h12345678);
        vecs[0] = '{32'h00000014, 32'hDEADBEEF, 1'b0, 4};
        vecs[1] = '{32'h00000016, 32'h00000000, 1'b1, 0};
        vecs[2] = '{32'h00000400, 32'h00000000, 1'b1, 1};
        vecs[3] = '{32'h00000000, 32'hA5A50001, 1'b0, 0};
        vecs[4] = '{32'h000003FC, 32'hCAFEF00D, 1'b0, 2};
        vecs[5] = '{32'h00000004, 32'h12345678, 1'b0, 0};
        vecs[6] = '{32'h000003FD, 32'h00000000, 1'b1, 0};
        vecs[7] = '{32'h80000004, 32'h00000000, 1'b1, 0};
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].exp_data, vecs[v].exp_err, vecs[v].hold,
                          1'b0, 8'd0, 32'd0, $sformatf("tbl%0d", v));
        end

        // Load and accept to the same index on the same edge
        loadWord(8'd7, 32'h1);
        applyStimulus(32'h1C, 32'h1, 1'b0, 0, 1'b1, 8'd7, 32'h2, "coll_old");
        applyStimulus(32'h1C, 32'h2, 1'b0, 0, 1'b0, 8'd0, 32'd0, "coll_new");

        // Reset during WAIT drops the request
        req_addr_valid = 1'b1;
        req_addr       = 32'h14;
        step();
        req_addr_valid = 1'b0;
        checkOutput("midrst_wait_valid", {31'b0, rsp_data_valid}, 32'd0);
        checkOutput("midrst_wait_ready", {31'b0, req_addr_ready}, 32'd0);
        rst = 1'b1;
        step();
        checkOutput("midrst_valid", {31'b0, rsp_data_valid}, 32'd0);
        checkOutput("midrst_data", rsp_data, 32'd0);
        rst            = 1'b0;
        rsp_data_ready = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            checkOutput("midrst_dropped", {31'b0, rsp_data_valid}, 32'd0);
        end
        applyStimulus(32'h14, 32'hDEADBEEF, 1'b0, 0, 1'b0, 8'd0, 32'd0, "midrst_next");

        // Randomized fetches against the word-array model
        for (int i = 0; i < 256; i++) begin
            loadWord(8'(i), $urandom());
        end
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 7);
            a    = {22'b0, 8'($urandom()), 2'b00};
            if (kind == 6) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 7) a = a | (32'h400 << $urandom_range(0, 21));
            ee = (a[1:0] != 2'b00) || (a >= 32'h400);
            ed = ee ? 32'h0 : model_mem[a[9:2]];
            coll = ($urandom_range(0, 3) == 0);
            cidx = ($urandom_range(0, 1) == 0) ? a[9:2] : 8'($urandom());
            cval = $urandom();
            applyStimulus(a, ed, ee, $urandom_range(0, 3), coll, cidx, cval, $sformatf("rnd%0d", t));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                req_addr       = $urandom();
                rsp_data_ready = 1'($urandom_range(0, 1));
                step();
                rsp_data_ready = 1'b0;
                checkOutput("rnd_gap_valid", {31'b0, rsp_data_valid}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
